// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: PCM words arrive on a valid/ready stream into
// per-channel holding registers and are shifted out MSB first on sd_o, with ws_o framing.
module i2s_tx #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  cfg_ch_single,
    input  logic                  cfg_ch_sel,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  rx_ch,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  ws_o,
    output logic                  sd_o,
    output logic                  underrun_o
);

    localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    ch_e                   ch_cnt,     ch_nxt;
    logic [CW-1:0]         bit_cnt,    bit_nxt;
    logic [DATA_WIDTH-1:0] shift,      shift_nxt;
    logic [DATA_WIDTH-1:0] hold_l,     hold_l_nxt;
    logic [DATA_WIDTH-1:0] hold_r,     hold_r_nxt;
    logic [1:0]            hold_valid, hold_valid_nxt;
    logic                  ws_nxt, sd_nxt, underrun_nxt;

    logic                  rx_drop;
    logic                  rx_accept;
    logic                  slot_active;
    logic                  cur_valid;
    logic [DATA_WIDTH-1:0] cur_word;

    // Handshake: a word transfers on a posedge where rx_valid && rx_ready. rx_ready
    // depends only on the tagged holding register (and the drop rule in single-channel
    // mode), never on the serial side, so a register drained this cycle accepts next cycle.
    always_comb begin
        rx_drop   = cfg_ch_single && (rx_ch != cfg_ch_sel);
        rx_ready  = rx_drop || !(rx_ch ? hold_valid[1] : hold_valid[0]);
        rx_accept = rx_valid && rx_ready && !rx_drop;
    end

    always_comb begin
        slot_active = !cfg_ch_single || (ch_cnt == CH_RIGHT) == cfg_ch_sel;
        cur_valid   = (ch_cnt == CH_RIGHT) ? hold_valid[1] : hold_valid[0];
        cur_word    = (ch_cnt == CH_RIGHT) ? hold_r : hold_l;
    end

    always_comb begin
        ch_nxt         = ch_cnt;
        bit_nxt        = bit_cnt;
        shift_nxt      = shift;
        hold_l_nxt     = hold_l;
        hold_r_nxt     = hold_r;
        hold_valid_nxt = hold_valid;
        ws_nxt         = 1'b0;
        sd_nxt         = 1'b0;
        underrun_nxt   = 1'b0;

        if (rx_accept) begin
            if (rx_ch) begin
                hold_r_nxt        = rx_data;
                hold_valid_nxt[1] = 1'b1;
            end else begin
                hold_l_nxt        = rx_data;
                hold_valid_nxt[0] = 1'b1;
            end
        end

        if (!en) begin
            // Park on the last bit of a dummy right slot so enabling starts a clean frame.
            ch_nxt    = CH_RIGHT;
            bit_nxt   = BIT_LAST;
            shift_nxt = '0;
        end else begin
            if (bit_cnt == BIT_LAST) begin
                bit_nxt = '0;
                ch_nxt  = (ch_cnt == CH_LEFT) ? CH_RIGHT : CH_LEFT;
            end else begin
                bit_nxt = bit_cnt + CW'(1);
            end
            // ws leads the data by one bit-clock: it flips alongside the old slot's LSB.
            ws_nxt = (ch_nxt == CH_RIGHT);

            if (bit_cnt == '0) begin
                if (!slot_active) begin
                    shift_nxt = '0;
                end else if (cur_valid) begin
                    sd_nxt    = cur_word[DATA_WIDTH-1];
                    shift_nxt = cur_word << 1;
                    if (ch_cnt == CH_RIGHT) hold_valid_nxt[1] = 1'b0;
                    else                    hold_valid_nxt[0] = 1'b0;
                end else begin
                    shift_nxt    = '0;
                    underrun_nxt = 1'b1;
                end
            end else begin
                sd_nxt    = shift[DATA_WIDTH-1];
                shift_nxt = shift << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_cnt     <= CH_RIGHT;
            bit_cnt    <= BIT_LAST;
            shift      <= '0;
            hold_l     <= '0;
            hold_r     <= '0;
            hold_valid <= '0;
            ws_o       <= 1'b0;
            sd_o       <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            ch_cnt     <= ch_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            hold_l     <= hold_l_nxt;
            hold_r     <= hold_r_nxt;
            hold_valid <= hold_valid_nxt;
            ws_o       <= ws_nxt;
            sd_o       <= sd_nxt;
            underrun_o <= underrun_nxt;
        end
    end

endmodule
